// File: rtl/trace_pkg.sv
// Shared definitions for the trace acquisition controller.
//   state_t  : controller FSM states
//   phase_t  : which byte of the UART stream is currently in flight
//   CMD_INC  : command byte that bumps the IDELAY tap by one
//   MARKER   : buffer byte reserved for "AES done" samples
//   SAT_MAX  : largest sensor code stored as data (keeps MARKER unique)
//   MAX_TAP  : highest IDELAY tap value
package trace_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CFG      = 4'd1,
        ST_SETTLE_W = 4'd2,
        ST_ARM      = 4'd3,
        ST_CAPT     = 4'd4,
        ST_HDR0     = 4'd5,
        ST_HDR1     = 4'd6,
        ST_RD       = 4'd7,
        ST_SEND     = 4'd8,
        ST_WAIT_TX  = 4'd9,
        ST_HOLD     = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        PH_TAP  = 2'd0,
        PH_CNT  = 2'd1,
        PH_DATA = 2'd2
    } phase_t;

    localparam logic [7:0] CMD_INC = 8'd250;
    localparam logic [7:0] MARKER  = 8'hFF;
    localparam logic [7:0] SAT_MAX = 8'hFE;
    localparam logic [4:0] MAX_TAP = 5'd31;

    // Tap increment with wrap from the top tap back to zero.
    function automatic logic [4:0] next_tap(input logic [4:0] t);
        return (t == MAX_TAP) ? 5'd0 : t + 5'd1;
    endfunction

endpackage

// File: rtl/uart_byte_sender.sv
// One-byte transmit handshake towards uart_tx.
//   clk, rstn : clock, asynchronous active-low reset
//   go        : one-cycle request to send din
//   din       : byte to send, sampled on go
//   tx_done   : transmit-complete strobe from uart_tx
//   tx_dv     : one-cycle transmit request (the cycle after go)
//   tx_byte   : byte being sent, held until the next go
//   sent      : one-cycle strobe, the accepted tx_done
module uart_byte_sender (
    input  logic       clk,
    input  logic       rstn,
    input  logic       go,
    input  logic [7:0] din,
    input  logic       tx_done,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    output logic       sent
);

    logic pend;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_dv   <= 1'b0;
            tx_byte <= 8'h00;
            pend    <= 1'b0;
        end else begin
            tx_dv <= go;
            if (go) begin
                tx_byte <= din;
                pend    <= 1'b1;
            end else if (sent) begin
                pend <= 1'b0;
            end
        end
    end

    // A strobe coincident with tx_dv belongs to an earlier transfer, so only
    // strobes from the cycle after the request onward complete this byte.
    assign sent = pend & ~tx_dv & tx_done;

endmodule

// File: rtl/trace_capture_ctrl.sv
// Sequences one side-channel trace: command decode, IDELAY tap load, AES
// start, NSAMP-sample capture into the external buffer, then a UART stream
// of {tap, trace_count, sample0 .. sampleN-1}, followed by a hold-off.
//   clk, rstn         : clock, asynchronous active-low reset
//   cmd_valid/cmd_byte: UART receive command strobe and byte
//   busy              : FSM not idle
//   delay_tap/ld      : IDELAY CNTVALUEIN and one-cycle load strobe
//   aes_start/done    : AES start pulse and combined done level
//   sensor_code       : decoded TDC value
//   buf_we/waddr/wdata: sample buffer write port
//   buf_raddr/rdata   : sample buffer read port (1-cycle read latency)
//   tx_dv/byte/done   : uart_tx handshake
//   trace_count       : traces started, modulo 256
module trace_capture_ctrl
    import trace_pkg::*;
#(
    parameter int NSAMP   = 2048,
    parameter int AW      = 11,
    parameter int SETTLE  = 8,
    parameter int HOLDOFF = 4096
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    input  logic [7:0]    cmd_byte,
    output logic          busy,
    output logic [4:0]    delay_tap,
    output logic          delay_ld,
    output logic          aes_start,
    input  logic          aes_done,
    input  logic [7:0]    sensor_code,
    output logic          buf_we,
    output logic [AW-1:0] buf_waddr,
    output logic [7:0]    buf_wdata,
    output logic [AW-1:0] buf_raddr,
    input  logic [7:0]    buf_rdata,
    output logic          tx_dv,
    output logic [7:0]    tx_byte,
    input  logic          tx_done,
    output logic [7:0]    trace_count
);

    // One wait counter serves both the settle and the hold-off phases.
    localparam int WMAX = (SETTLE > HOLDOFF) ? SETTLE : HOLDOFF;
    localparam int WW   = $clog2(WMAX + 1);

    localparam logic [AW:0]   LAST_IDX    = (AW+1)'(NSAMP - 1);
    localparam logic [WW-1:0] SETTLE_LAST = WW'(SETTLE - 1);
    localparam logic [WW-1:0] HOLD_LAST   = WW'(HOLDOFF - 1);

    state_t        state;
    phase_t        phase;
    logic [AW:0]   widx;
    logic [AW:0]   ridx;
    logic [WW-1:0] wcnt;
    logic [4:0]    tap;
    logic [7:0]    tcount;

    logic          cmd_set;
    logic          cmd_inc;
    logic          snd_go;
    logic [7:0]    snd_din;
    logic          snd_sent;

    // Sensor codes above SAT_MAX are clipped so MARKER only ever means
    // "AES done was high on this sample".
    function automatic logic [7:0] sat_code(input logic [7:0] c);
        return (c > SAT_MAX) ? SAT_MAX : c;
    endfunction

    assign cmd_set = cmd_valid && (cmd_byte < 8'd32);
    assign cmd_inc = cmd_valid && (cmd_byte == CMD_INC);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            phase  <= PH_TAP;
            widx   <= '0;
            ridx   <= '0;
            wcnt   <= '0;
            tap    <= 5'd0;
            tcount <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_set) begin
                        tap   <= cmd_byte[4:0];
                        state <= ST_CFG;
                    end else if (cmd_inc) begin
                        tap   <= next_tap(tap);
                        state <= ST_CFG;
                    end
                end
                ST_CFG: begin
                    wcnt  <= '0;
                    state <= ST_SETTLE_W;
                end
                ST_SETTLE_W: begin
                    if (wcnt == SETTLE_LAST) begin
                        wcnt  <= '0;
                        state <= ST_ARM;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                ST_ARM: begin
                    tcount <= tcount + 8'd1;
                    widx   <= '0;
                    state  <= ST_CAPT;
                end
                ST_CAPT: begin
                    if (widx == LAST_IDX) begin
                        widx  <= '0;
                        state <= ST_HDR0;
                    end else begin
                        widx <= widx + (AW+1)'(1);
                    end
                end
                ST_HDR0: begin
                    phase <= PH_TAP;
                    state <= ST_WAIT_TX;
                end
                ST_HDR1: begin
                    phase <= PH_CNT;
                    state <= ST_WAIT_TX;
                end
                ST_RD: begin
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    phase <= PH_DATA;
                    state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (snd_sent) begin
                        case (phase)
                            PH_TAP: state <= ST_HDR1;
                            PH_CNT: begin
                                ridx  <= '0;
                                state <= ST_RD;
                            end
                            default: begin
                                if (ridx == LAST_IDX) begin
                                    ridx  <= '0;
                                    wcnt  <= '0;
                                    state <= ST_HOLD;
                                end else begin
                                    ridx  <= ridx + (AW+1)'(1);
                                    state <= ST_RD;
                                end
                            end
                        endcase
                    end
                end
                ST_HOLD: begin
                    if (wcnt == HOLD_LAST) begin
                        wcnt  <= '0;
                        state <= ST_IDLE;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state != ST_IDLE);
    assign delay_tap   = tap;
    assign delay_ld    = (state == ST_CFG);
    assign aes_start   = (state == ST_ARM);
    assign trace_count = tcount;

    assign buf_we    = (state == ST_CAPT);
    assign buf_waddr = widx[AW-1:0];
    assign buf_wdata = buf_we ? (aes_done ? MARKER : sat_code(sensor_code)) : 8'h00;

    // The read address is presented in RD; the RAM answers during SEND.
    assign buf_raddr = ridx[AW-1:0];

    assign snd_go  = (state == ST_HDR0) || (state == ST_HDR1) || (state == ST_SEND);
    assign snd_din = (state == ST_HDR0) ? {3'b000, tap} :
                     (state == ST_HDR1) ? tcount : buf_rdata;

    uart_byte_sender u_sender (
        .clk     (clk),
        .rstn    (rstn),
        .go      (snd_go),
        .din     (snd_din),
        .tx_done (tx_done),
        .tx_dv   (tx_dv),
        .tx_byte (tx_byte),
        .sent    (snd_sent)
    );

endmodule

// File: tb/tb_trace_capture_ctrl.sv
module tb_trace_capture_ctrl;

    localparam int NSAMP   = 16;
    localparam int AW      = 4;
    localparam int SETTLE  = 8;
    localparam int HOLDOFF = 20;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid;
    logic [7:0]    cmd_byte;
    logic          busy;
    logic [4:0]    delay_tap;
    logic          delay_ld;
    logic          aes_start;
    logic          aes_done;
    logic [7:0]    sensor_code;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [7:0]    buf_wdata;
    logic [AW-1:0] buf_raddr;
    logic [7:0]    buf_rdata;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          tx_done;
    logic [7:0]    trace_count;

    always #5 clk = ~clk;

    trace_capture_ctrl #(
        .NSAMP(NSAMP), .AW(AW), .SETTLE(SETTLE), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
        .busy(busy), .delay_tap(delay_tap), .delay_ld(delay_ld),
        .aes_start(aes_start), .aes_done(aes_done), .sensor_code(sensor_code),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .buf_raddr(buf_raddr), .buf_rdata(buf_rdata), .tx_dv(tx_dv),
        .tx_byte(tx_byte), .tx_done(tx_done), .trace_count(trace_count)
    );

    int vec = 0;
    int err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // external sample RAM, synchronous read
    logic [7:0] mem [NSAMP];
    always @(posedge clk) begin
        if (buf_we) mem[buf_waddr] <= buf_wdata;
        buf_rdata <= mem[buf_raddr];
    end

    // behavioural model state
    int         cmd_cyc = -100000;  // cycle index of the CFG cycle of the current trace
    logic [4:0] m_tap = 5'd0;
    logic [7:0] m_cnt = 8'd0;
    logic [7:0] m_samp [NSAMP];
    logic [7:0] rx_bytes [NSAMP+2];
    int rx_n = 0, done_n = 0, last_done_cyc = 0;
    int n_ld = 0, n_st = 0, n_we = 0;
    bit pend = 0;
    logic [7:0] pend_byte = 8'h00;
    int smode = 0, dmode = 0;
    bit spurious = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // stimulus: sensor/aes_done per capture slot, and a uart_tx model
    initial begin
        int k;
        bit u_pend;
        int u_wait;
        u_pend = 0; u_wait = 0;
        aes_done = 1'b0; sensor_code = 8'h00; tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            k = cyc - cmd_cyc - 10;
            case (smode)
                0: begin aes_done = 1'b0; sensor_code = 8'(cyc * 37 + 3); end
                1: begin aes_done = (k >= 3 && k <= 5); sensor_code = 8'hFF; end
                default: begin aes_done = 1'($urandom_range(0, 1)); sensor_code = 8'($urandom); end
            endcase
            tx_done = 1'b0;
            if (!rstn) begin
                u_pend = 0;
            end else if (u_pend) begin
                if (u_wait == 0) begin tx_done = 1'b1; u_pend = 0; end
                else u_wait--;
            end else if (tx_dv) begin
                u_pend = 1;
                u_wait = (dmode != 0) ? int'($urandom_range(9, 199)) : 2;
                if (spurious) tx_done = 1'b1;
            end else if (spurious && (cyc - cmd_cyc) >= 1 && (cyc - cmd_cyc) < 10 + NSAMP) begin
                tx_done = cyc[0];
            end
        end
    end

    // compare process: every cycle out of reset
    always @(negedge clk) begin
        int rel;
        bit e_we;
        logic [7:0] ew, eb;
        if (!rstn) begin
            pend = 0;
        end else begin
            rel  = cyc - cmd_cyc;
            e_we = (rel >= 10 && rel < 10 + NSAMP);
            chk("delay_tap", delay_tap, m_tap);
            chk("trace_count", trace_count, m_cnt);
            if (rel == 0 || delay_ld) chk("delay_ld", delay_ld, rel == 0);
            if (delay_ld) n_ld++;
            if (rel == 9 || aes_start) chk("aes_start", aes_start, rel == 9);
            if (aes_start) n_st++;
            if (rel == 9) m_cnt = m_cnt + 8'd1;
            if (e_we || buf_we) begin
                chk("buf_we", buf_we, e_we);
                if (e_we) begin
                    ew = aes_done ? 8'hFF : ((sensor_code > 8'hFE) ? 8'hFE : sensor_code);
                    m_samp[rel - 10] = ew;
                    chk("buf_waddr", buf_waddr, rel - 10);
                    chk("buf_wdata", buf_wdata, ew);
                end
            end
            if (buf_we) n_we++;
            if (tx_dv) begin
                chk("one_dv_per_byte", pend, 1'b0);
                if (rx_n < NSAMP + 2) begin
                    eb = (rx_n == 0) ? {3'b000, m_tap} : (rx_n == 1) ? m_cnt : m_samp[rx_n - 2];
                    chk("tx_byte", tx_byte, eb);
                    rx_bytes[rx_n] = tx_byte;
                end else begin
                    chk("tx_extra_byte", rx_n, NSAMP + 1);
                end
                rx_n++;
                pend = 1;
                pend_byte = tx_byte;
            end else if (pend) begin
                chk("tx_byte_hold", tx_byte, pend_byte);
                chk("busy_during_tx", busy, 1'b1);
                if (tx_done) begin
                    pend = 0;
                    done_n++;
                    last_done_cyc = cyc;
                end
            end
        end
    end

    // drives the command during the current cycle (call at posedge+1)
    task automatic send_cmd(input logic [7:0] b, input bit accept);
        cmd_valid = 1'b1; cmd_byte = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_byte = 8'h00;
        if (accept) begin
            cmd_cyc = cyc;
            rx_n = 0; done_n = 0; n_ld = 0; n_st = 0; n_we = 0;
            if (b < 8'd32) m_tap = b[4:0];
            else if (b == 8'd250) m_tap = m_tap + 5'd1;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin @(posedge clk); #1; end
    endtask

    task automatic wait_trace();
        int t;
        t = 0;
        while (done_n < NSAMP + 2 && t < 8000) begin @(posedge clk); #1; t++; end
        chk("trace_complete", done_n, NSAMP + 2);
        chk("stream_len", rx_n, NSAMP + 2);
    endtask

    initial begin
        int t;
        cmd_valid = 1'b0; cmd_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_delay_ld", delay_ld, 1'b0);
        chk("rst_aes_start", aes_start, 1'b0);
        chk("rst_buf_we", buf_we, 1'b0);
        chk("rst_tx_dv", tx_dv, 1'b0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_trace_count", trace_count, 8'h00);
        chk("rst_delay_tap", delay_tap, 5'd0);
        chk("rst_buf_waddr", buf_waddr, 4'd0);
        chk("rst_buf_raddr", buf_raddr, 4'd0);
        chk("rst_buf_wdata", buf_wdata, 8'h00);
        rstn = 1'b1;
        @(posedge clk); #1;

        // trace 1: tap 5, plain sensor pattern, short uart latency
        send_cmd(8'd5, 1);
        wait_trace();
        chk("t1_hdr_tap", rx_bytes[0], 8'h05);
        chk("t1_hdr_cnt", rx_bytes[1], 8'h01);
        chk("t1_ld_pulses", n_ld, 1);
        chk("t1_start_pulses", n_st, 1);
        chk("t1_writes", n_we, NSAMP);
        for (int i = 0; i < NSAMP; i++) chk("t1_mem", mem[i], m_samp[i]);

        // last HOLD cycle drops a command; the next (idle) cycle accepts one
        wait_until(last_done_cyc + HOLDOFF);
        chk("busy_last_hold", busy, 1'b1);
        send_cmd(8'd7, 0);
        chk("busy_after_hold", busy, 1'b0);

        // trace 2: tap 31, marker window 3..5, stray tx_done strobes, cmd during CAPT
        smode = 1; spurious = 1;
        send_cmd(8'd31, 1);
        wait_until(cmd_cyc + 12);
        send_cmd(8'd7, 0);
        wait_trace();
        chk("t2_hdr_tap", rx_bytes[0], 8'h1F);
        chk("t2_hdr_cnt", rx_bytes[1], 8'h02);
        for (int i = 0; i < NSAMP; i++) begin
            chk("t2_mem", mem[i], (i >= 3 && i <= 5) ? 8'hFF : 8'hFE);
            chk("t2_payload", rx_bytes[i + 2], (i >= 3 && i <= 5) ? 8'hFF : 8'hFE);
        end
        spurious = 0;

        // trace 3: increment wraps 31 -> 0, random data, random uart latency
        wait_until(last_done_cyc + HOLDOFF + 1);
        smode = 2; dmode = 1;
        send_cmd(8'd250, 1);
        wait_trace();
        chk("t3_hdr_tap", rx_bytes[0], 8'h00);
        chk("t3_hdr_cnt", rx_bytes[1], 8'h03);

        // trace 4: reset in the middle of the payload
        wait_until(last_done_cyc + HOLDOFF + 1);
        smode = 0; dmode = 0;
        send_cmd(8'd9, 1);
        t = 0;
        while (rx_n < 7 && t < 2000) begin @(posedge clk); #1; t++; end
        chk("t4_reach_payload", rx_n >= 7, 1'b1);
        #2;
        rstn = 1'b0;
        m_tap = 5'd0; m_cnt = 8'd0; cmd_cyc = -100000; rx_n = 0; done_n = 0;
        #1;
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_tx_dv", tx_dv, 1'b0);
        chk("rstmid_trace_count", trace_count, 8'h00);
        chk("rstmid_delay_tap", delay_tap, 5'd0);
        chk("rstmid_buf_we", buf_we, 1'b0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        send_cmd(8'd3, 1);
        wait_trace();
        chk("t5_hdr_tap", rx_bytes[0], 8'h03);
        chk("t5_hdr_cnt", rx_bytes[1], 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
